// File: rtl/axi_ram_slave_pkg.sv
// rtl/axi_ram_slave_pkg.sv - shared types and constants for the AXI-to-burst-RAM slave
package axi_ram_slave_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BEAT_BYTES  = 8;

endpackage

// File: rtl/axi_ram_slave_if.sv
// rtl/axi_ram_slave_if.sv - AXI4 write/read channel bundle (no WSTRB, INCR only)
interface axi_ram_slave_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] s_awaddr;
  logic [LEN_W-1:0]  s_awlen;
  logic              s_awvalid;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic              s_wlast;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
           s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rlast, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
           s_araddr, s_arlen, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rlast, s_rvalid
  );
endinterface

// File: rtl/axi_ram_slave_run_addr.sv
// rtl/axi_ram_slave_run_addr.sv - beat address counter and RAM run-base register
module axi_ram_run_addr
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              en,
  output logic [ADDR_W-1:0] ram_addr
);

  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] run_base;
  logic              en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr <= '0;
      run_base  <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= en;
      if (load)
        beat_addr <= load_addr;
      else if (en)
        beat_addr <= beat_addr + ADDR_W'(BEAT_BYTES);
      if (en && !en_q)
        run_base <= beat_addr;
    end
  end

  // The RAM counts internally within a run, so only the first beat shows the live address.
  assign ram_addr = en_q ? run_base : beat_addr;

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI4 INCR burst slave driving a byte-addressed burst RAM
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_ram_slave_if.slave    s,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  state_t            state;
  logic              last_grant;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_cnt;
  logic              err;
  logic              awready_q, arready_q, bvalid_q, rvalid_q, rlast_q;
  logic [1:0]        bresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_w, grant_r, final_beat, rd_pending, wlast_bad;

  // last_grant = 1 means read was granted last; its reset value lets write win the first tie.
  assign grant_w    = (state == IDLE) && s.s_awvalid && (!s.s_arvalid || last_grant);
  assign grant_r    = (state == IDLE) && s.s_arvalid && !grant_w;
  assign final_beat = (beat_cnt == {1'b0, len_q});
  assign rd_pending = (beat_cnt <= {1'b0, len_q});
  assign wlast_bad  = (s.s_wlast != final_beat);

  assign ram_wr_en = (state == WRITE) && s.s_wvalid;
  assign ram_rd_en = (state == READ) && rd_pending && (!rvalid_q || s.s_rready);
  assign ram_data  = ram_wr_en ? s.s_wdata : {DATA_W{1'bz}};

  assign s.s_awready = awready_q;
  assign s.s_arready = arready_q;
  assign s.s_wready  = (state == WRITE);
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rlast   = rlast_q;
  assign s.s_rresp   = RESP_OKAY;

  axi_ram_run_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant_w),
    .load_addr (s.s_awaddr & ~ADDR_W'(BEAT_BYTES - 1)),
    .en        (ram_wr_en),
    .ram_addr  (ram_wr_addr)
  );

  axi_ram_run_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant_r),
    .load_addr (s.s_araddr & ~ADDR_W'(BEAT_BYTES - 1)),
    .en        (ram_rd_en),
    .ram_addr  (ram_rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      len_q      <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
      awready_q  <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (grant_w) begin
            awready_q  <= 1'b1;
            len_q      <= s.s_awlen;
            last_grant <= 1'b0;
            state      <= WRITE;
          end else if (grant_r) begin
            arready_q  <= 1'b1;
            len_q      <= s.s_arlen;
            last_grant <= 1'b1;
            state      <= READ;
          end
        end
        WRITE: begin
          if (ram_wr_en) begin
            if (wlast_bad)
              err <= 1'b1;
            if (final_beat) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              beat_cnt <= '0;
              state    <= WRESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WRESP: begin
          if (s.s_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            err      <= 1'b0;
            state    <= IDLE;
          end
        end
        READ: begin
          // A new fetch also retires the beat currently on the R channel.
          if (ram_rd_en) begin
            rdata_q  <= ram_data;
            rvalid_q <= 1'b1;
            rlast_q  <= final_beat;
            beat_cnt <= beat_cnt + 1'b1;
          end else if (rvalid_q && s.s_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q)
              state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - randomized bench for axi_ram_slave with burst RAM and memory model
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_wr_en, ram_rd_en;
  logic [29:0] ram_wr_addr, ram_rd_addr;
  wire  [63:0] ram_data;

  axi_ram_slave_if #(.ADDR_W(30), .DATA_W(64), .LEN_W(8)) axi ();

  axi_ram_slave #(.ADDR_W(30), .DATA_W(64), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (axi.slave),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_data    (ram_data)
  );

  always #5 clk = ~clk;

  // Burst RAM: internal offset counts up while the enable stays high, restarts when it drops.
  logic [63:0] mem [0:2047];
  int unsigned wr_run, rd_run;
  logic [29:0] wr_eff, rd_eff;
  assign wr_eff   = ram_wr_addr + 30'(wr_run * 8);
  assign rd_eff   = ram_rd_addr + 30'(rd_run * 8);
  assign ram_data = ram_rd_en ? mem[rd_eff[13:3]] : 64'bz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_run <= 0;
      rd_run <= 0;
    end else begin
      if (ram_wr_en) mem[wr_eff[13:3]] <= ram_data;
      wr_run <= ram_wr_en ? wr_run + 1 : 0;
      rd_run <= ram_rd_en ? rd_run + 1 : 0;
    end
  end

  logic [63:0] ref_mem [logic [29:0]];
  int n_tests = 0, n_fail = 0, overlap = 0;

  always @(negedge clk) begin
    #3;
    if (ram_wr_en && ram_rd_en) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  task automatic aw_req(input logic [29:0] a, input int len);
    int n = 0;
    axi.s_awaddr = a; axi.s_awlen = 8'(len); axi.s_awvalid = 1'b1;
    @(negedge clk);
    while (!axi.s_awready && n < 100) begin @(negedge clk); n++; end
    check("awready", axi.s_awready, 1);
    @(negedge clk);
    axi.s_awvalid = 1'b0;
  endtask

  task automatic ar_req(input logic [29:0] a, input int len);
    int n = 0;
    axi.s_araddr = a; axi.s_arlen = 8'(len); axi.s_arvalid = 1'b1;
    @(negedge clk);
    while (!axi.s_arready && n < 100) begin @(negedge clk); n++; end
    check("arready", axi.s_arready, 1);
    @(negedge clk);
    axi.s_arvalid = 1'b0;
  endtask

  task automatic do_wbeats(input logic [29:0] a, input int len, input int bad_beat,
                           input int gap_beat, input int gap_len, input bit rnd,
                           input logic [63:0] d0, input logic [63:0] step);
    logic [29:0] base = a;
    logic [63:0] d;
    bit prev = 0, err = 0;
    int g, n = 0;
    for (int k = 0; k <= len; k++) begin
      g = (k == gap_beat) ? gap_len : ((rnd && $urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0);
      if (g > 0) begin
        axi.s_wvalid = 1'b0;
        repeat (g) @(negedge clk);
        prev = 0;
      end
      d = rnd ? {$urandom, $urandom} : d0 + 64'(k) * step;
      axi.s_wdata  = d;
      axi.s_wvalid = 1'b1;
      axi.s_wlast  = (bad_beat >= 0) ? (k == bad_beat) : (k == len);
      if (axi.s_wlast != (k == len)) err = 1;
      if (!prev) base = a + 30'(8 * k);
      #1;
      check("wr_en", ram_wr_en, 1);
      check("wr_addr", ram_wr_addr, base);
      check("wr_bus", ram_data, d);
      ref_mem[a + 30'(8 * k)] = d;
      prev = 1;
      @(negedge clk);
    end
    axi.s_wvalid = 1'b0; axi.s_wlast = 1'b0; axi.s_bready = 1'b1;
    while (!axi.s_bvalid && n < 100) begin @(negedge clk); n++; end
    check("bvalid", axi.s_bvalid, 1);
    check("bresp", axi.s_bresp, err ? 2'b10 : 2'b00);
    @(negedge clk);
    axi.s_bready = 1'b0;
  endtask

  task automatic do_rbeats(input logic [29:0] a, input int len, input int stall_beat,
                           input int stall_len, input bit rnd);
    logic [63:0] held;
    int k = 0, n = 0;
    while (k <= len && n < 3000) begin
      axi.s_rready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (axi.s_rvalid && k == stall_beat) begin
        held = axi.s_rdata;
        axi.s_rready = 1'b0;
        repeat (stall_len) begin
          #1;
          check("stall_rd_en", ram_rd_en, 0);
          check("stall_rdata", axi.s_rdata, held);
          check("stall_rvalid", axi.s_rvalid, 1);
          @(negedge clk);
        end
        axi.s_rready = 1'b1;
        #1;
        if (k < len) begin
          check("restart_rd_en", ram_rd_en, 1);
          check("restart_addr", ram_rd_addr, a + 30'(8 * (k + 1)));
        end
        stall_beat = -1;
      end
      if (axi.s_rvalid && axi.s_rready) begin
        check("rdata", axi.s_rdata, ref_rd(a + 30'(8 * k)));
        check("rlast", axi.s_rlast, k == len);
        k++;
      end
      @(negedge clk);
      n++;
    end
    axi.s_rready = 1'b0;
    check("rd_beats", k, len + 1);
  endtask

  task automatic wr_burst(input logic [29:0] a, input int len, input int bad_beat,
                          input int gap_beat, input int gap_len, input bit rnd,
                          input logic [63:0] d0, input logic [63:0] step);
    aw_req(a, len);
    do_wbeats(a & ~30'h7, len, bad_beat, gap_beat, gap_len, rnd, d0, step);
  endtask

  task automatic rd_burst(input logic [29:0] a, input int len, input int stall_beat,
                          input int stall_len, input bit rnd);
    ar_req(a, len);
    do_rbeats(a & ~30'h7, len, stall_beat, stall_len, rnd);
  endtask

  task automatic reset_state_check(input string tag);
    #1;
    check({tag, "_awready"}, axi.s_awready, 0);
    check({tag, "_arready"}, axi.s_arready, 0);
    check({tag, "_wready"}, axi.s_wready, 0);
    check({tag, "_bvalid"}, axi.s_bvalid, 0);
    check({tag, "_rvalid"}, axi.s_rvalid, 0);
    check({tag, "_rlast"}, axi.s_rlast, 0);
    check({tag, "_rdata"}, axi.s_rdata, 0);
    check({tag, "_wr_en"}, ram_wr_en, 0);
    check({tag, "_rd_en"}, ram_rd_en, 0);
    check({tag, "_rd_addr"}, ram_rd_addr, 0);
    check({tag, "_ram_data"}, ram_data, 64'bz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [29:0] ra;
    for (int i = 0; i < 2048; i++) mem[i] = 64'h0;
    rst_n = 1'b0;
    axi.s_awaddr = '0; axi.s_awlen = '0; axi.s_awvalid = 1'b0;
    axi.s_wdata = '0; axi.s_wlast = 1'b0; axi.s_wvalid = 1'b0; axi.s_bready = 1'b0;
    axi.s_araddr = '0; axi.s_arlen = '0; axi.s_arvalid = 1'b0; axi.s_rready = 1'b0;
    repeat (3) @(negedge clk);
    reset_state_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr_burst(30'h40, 0, -1, -1, 0, 0, 64'h0011223344556677, 64'h0);
    rd_burst(30'h40, 0, -1, 0, 0);
    wr_burst(30'h100, 3, -1, -1, 0, 0, 64'h0101010101010101, 64'h0101010101010101);
    rd_burst(30'h100, 3, -1, 0, 0);
    wr_burst(30'h200, 3, -1, 2, 2, 0, 64'hA5A5000000000001, 64'h1);
    rd_burst(30'h200, 3, -1, 0, 0);
    wr_burst(30'h120, 3, -1, -1, 0, 1, 64'h0, 64'h0);
    rd_burst(30'h100, 7, 2, 3, 0);
    wr_burst(30'h400, 3, 1, -1, 0, 0, 64'hDEAD000000000000, 64'h10);
    rd_burst(30'h400, 3, -1, 0, 0);
    wr_burst(30'h3FFFFFF8, 1, -1, -1, 0, 0, 64'hCAFE0000BEEF0000, 64'h1);
    rd_burst(30'h3FFFFFF8, 1, -1, 0, 0);
    wr_burst(30'h1003, 255, -1, -1, 0, 1, 64'h0, 64'h0);
    rd_burst(30'h1000, 255, -1, 0, 1);

    // Arbitration ties from a fresh reset: write first, then read, then the waiting write.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi.s_awaddr = 30'h300; axi.s_awlen = 8'd0; axi.s_awvalid = 1'b1;
    axi.s_araddr = 30'h40;  axi.s_arlen = 8'd0; axi.s_arvalid = 1'b1;
    @(negedge clk);
    check("tie1_awready", axi.s_awready, 1);
    check("tie1_arready", axi.s_arready, 0);
    @(negedge clk);
    axi.s_awvalid = 1'b0;
    do_wbeats(30'h300, 0, -1, -1, 0, 1, 64'h0, 64'h0);
    axi.s_awaddr = 30'h308; axi.s_awvalid = 1'b1;
    @(negedge clk);
    check("tie2_arready", axi.s_arready, 1);
    check("tie2_awready", axi.s_awready, 0);
    @(negedge clk);
    axi.s_arvalid = 1'b0;
    do_rbeats(30'h40, 0, -1, 0, 0);
    aw_req(30'h308, 0);
    do_wbeats(30'h308, 0, -1, -1, 0, 1, 64'h0, 64'h0);
    rd_burst(30'h300, 1, -1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      ra = 30'h800 + 30'($urandom_range(0, 63) * 8) + 30'($urandom_range(0, 7));
      if ($urandom_range(1) == 1)
        wr_burst(ra, $urandom_range(0, 15), ($urandom_range(4) == 0) ? int'($urandom_range(0, 3)) : -1,
                 -1, 0, 1, 64'h0, 64'h0);
      else
        rd_burst(ra, $urandom_range(0, 15), -1, 0, 1);
    end

    // Reset in the middle of an 8-beat read.
    ar_req(30'h100, 7);
    axi.s_rready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rvalid", axi.s_rvalid, 1);
    rst_n = 1'b0;
    reset_state_check("midrst");
    @(negedge clk);
    axi.s_rready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd_burst(30'h100, 7, -1, 0, 1);

    check("no_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
